// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: shared types and constants for the 7-segment scan scheduler.
// Glyphs are {g,f,e,d,c,b,a}, active-low.
package seg_scan_pkg;
    typedef enum logic {BLANK, DRIVE} state_t;
    localparam int NUM_DIGITS = 4;
    localparam logic [3:0] ANODE_OFF = 4'hF;
    localparam logic [6:0] SEG_OFF = 7'h7F;
    // Listed F down to 0 so GLYPH[n] selects digit n
    localparam logic [15:0][6:0] GLYPH = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };
endpackage

// File: rtl/hex_to_seg7.sv
// hex_to_seg7: combinational nibble to active-low 7-segment glyph.
module hex_to_seg7
    import seg_scan_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    assign seg = GLYPH[nibble];
endmodule

// File: rtl/seg_scan_scheduler.sv
// seg_scan_scheduler: double-buffered, frame-synchronous 4-digit 7-segment scanner.
// Define SEG_LZ_BLANK_EN to suppress leading zeros on digits 3..1.
module seg_scan_scheduler
    import seg_scan_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_valid,
    input  logic [15:0] load_value,
    output logic        load_ready,
    output logic [6:0]  seg_cathode,
    output logic [3:0]  seg_anode_o,
    output logic        frame_done
);
    localparam int CW = $clog2((REFRESH_DIV > BLANK_CYCLES ? REFRESH_DIV : BLANK_CYCLES) + 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [15:0]   disp_reg, pend_reg;
    logic          pend_full;
    logic [3:0]    nib;
    logic [6:0]    glyph;
    logic          lz_off, blank_end, drive_end, frame_end;

    assign nib = disp_reg[4*idx +: 4];

    hex_to_seg7 u_glyph (
        .nibble(nib),
        .seg   (glyph)
    );

`ifdef SEG_LZ_BLANK_EN
    assign lz_off = (idx != 2'd0) && ((disp_reg >> {idx, 2'b00}) == 16'h0);
`else
    assign lz_off = 1'b0;
`endif

    assign blank_end  = (state == BLANK) && (cnt == CW'(BLANK_CYCLES - 1));
    assign drive_end  = (state == DRIVE) && (cnt == CW'(REFRESH_DIV - 1));
    assign frame_end  = drive_end && (idx == 2'(NUM_DIGITS - 1));
    assign load_ready = !pend_full;

    // Outputs are loaded on the edge entering each state so they line up with it exactly
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= BLANK;
            cnt         <= '0;
            idx         <= 2'd0;
            disp_reg    <= 16'h0;
            pend_reg    <= 16'h0;
            pend_full   <= 1'b0;
            seg_anode_o <= ANODE_OFF;
            seg_cathode <= SEG_OFF;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= frame_end;
            if (blank_end) begin
                state       <= DRIVE;
                cnt         <= '0;
                seg_anode_o <= lz_off ? ANODE_OFF : ~(4'b0001 << idx);
                seg_cathode <= lz_off ? SEG_OFF : glyph;
            end else if (drive_end) begin
                state       <= BLANK;
                cnt         <= '0;
                idx         <= idx + 2'd1;
                seg_anode_o <= ANODE_OFF;
                seg_cathode <= SEG_OFF;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (frame_end && pend_full) begin
                disp_reg  <= pend_reg;
                pend_full <= 1'b0;
            end else if (load_valid && !pend_full) begin
                pend_reg  <= load_value;
                pend_full <= 1'b1;
            end
        end
    end
endmodule
